// File: rtl/qtree_pkg.sv
// qtree_pkg: shared types for the quadtree control writer and lookup stages.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: RAM_D_WIDTH, ram_data_t {l,m,r}, writer FSM state_t, depth(s).
package qtree_pkg;

  localparam int RAM_D_WIDTH = 16;

  // Field order is the lookup stage RAM word layout: l in the MSBs, r in the LSBs.
  typedef struct packed {
    logic [RAM_D_WIDTH-1:0] l;
    logic [RAM_D_WIDTH-1:0] m;
    logic [RAM_D_WIDTH-1:0] r;
  } ram_data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_M,
    ST_GET_R,
    ST_WRITE,
    ST_INIT
  } state_t;

  // Number of nodes held by stage s.
  function automatic int depth(input int s);
    return 4 ** s;
  endfunction

endpackage

// File: rtl/qtree_init_sweep.sv
// qtree_init_sweep: stage/address walker covering every node of every stage.
// Latency: stage_o/addr_o are combinational "coordinates for the next write".
// Backpressure: none; advances once per cycle while adv_i is high.
// Ports: start_i restarts at (0,0); adv_i steps the counters; stage_o/addr_o
// give the coordinates to load at this edge; done_o flags the final node.
module qtree_init_sweep
  import qtree_pkg::*;
#(
  parameter int STAGES   = 4,
  parameter int A_WIDTH  = (STAGES > 1) ? 2 * (STAGES - 1) : 1,
  parameter int SG_WIDTH = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                adv_i,
  output logic [SG_WIDTH-1:0] stage_o,
  output logic [A_WIDTH-1:0]  addr_o,
  output logic                done_o
);

  // Counters hold the coordinates of the write currently on the outputs.
  logic [SG_WIDTH-1:0] cnt_stage;
  logic [A_WIDTH-1:0]  cnt_addr;
  logic [SG_WIDTH-1:0] nxt_stage;
  logic [A_WIDTH-1:0]  nxt_addr;
  logic                stage_end;

  always_comb begin
    stage_end = (cnt_addr == A_WIDTH'(depth(int'(cnt_stage)) - 1));
    nxt_stage = stage_end ? cnt_stage + SG_WIDTH'(1) : cnt_stage;
    nxt_addr  = stage_end ? '0 : cnt_addr + A_WIDTH'(1);
    done_o    = (int'(cnt_stage) == STAGES - 1) && stage_end;
    // On start the first write is (0,0); the counters load the same.
    stage_o   = start_i ? '0 : nxt_stage;
    addr_o    = start_i ? '0 : nxt_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      cnt_stage <= '0;
      cnt_addr  <= '0;
    end else if (adv_i) begin
      cnt_stage <= nxt_stage;
      cnt_addr  <= nxt_addr;
    end
  end

endmodule

// File: rtl/qtree_ctrl_writer.sv
// qtree_ctrl_writer: assembles host key words into {l,m,r} nodes and writes lookup stage RAMs; also runs an all-ones init sweep.
// Latency: node write on wr_* the cycle after the r-word handshake; sweep is one write per cycle.
// Backpressure: cmd_ready_o low in WRITE (one cycle) and for the whole INIT sweep.
// Ports: cmd_* host word stream, init_i sweep start, wr_* shared RAM write port
// (one-hot wr_en_o per stage), busy_o / done_o / err_o status.
// Optional: QTREE_ORDER_CHECK_EN suppresses nodes violating l<=m<=r and sets sticky err_o.
module qtree_ctrl_writer
  import qtree_pkg::*;
#(
  parameter int STAGES   = 4,
  parameter int D_WIDTH  = RAM_D_WIDTH,
  parameter int A_WIDTH  = (STAGES > 1) ? 2 * (STAGES - 1) : 1,
  parameter int SG_WIDTH = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_first_i,
  input  logic [SG_WIDTH-1:0]  cmd_stage_i,
  input  logic [A_WIDTH-1:0]   cmd_addr_i,
  input  logic [D_WIDTH-1:0]   cmd_data_i,
  input  logic                 init_i,
  output logic [STAGES-1:0]    wr_en_o,
  output logic [A_WIDTH-1:0]   wr_addr_o,
  output logic [3*D_WIDTH-1:0] wr_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_t              state;
  ram_data_t           node;        // partial node: l and m
  logic [SG_WIDTH-1:0] node_stage;
  logic [A_WIDTH-1:0]  node_addr;

  ram_data_t           wr_word;
  logic [A_WIDTH-1:0]  addr_mask;
  logic                hs;
  logic                stage_ok;
  logic                order_ok;
  logic                sweep_start;
  logic [SG_WIDTH-1:0] sw_stage;
  logic [A_WIDTH-1:0]  sw_addr;
  logic                sw_done;

  assign cmd_ready_o = (state == ST_IDLE) || (state == ST_GET_M) || (state == ST_GET_R);
  assign busy_o      = (state != ST_IDLE);
  assign hs          = cmd_valid_i && cmd_ready_o;
  // init_i also restarts from WRITE: that write is already on the outputs.
  assign sweep_start = init_i && (state != ST_INIT);
  assign stage_ok    = (int'(node_stage) < STAGES);

  always_comb begin
    wr_word   = node;
    wr_word.r = cmd_data_i;
    // Stage s decodes only its low max(2s,1) address bits.
    addr_mask = '0;
    for (int i = 0; i < A_WIDTH; i++) begin
      addr_mask[i] = (i < ((node_stage == '0) ? 1 : 2 * int'(node_stage)));
    end
`ifdef QTREE_ORDER_CHECK_EN
    order_ok = (node.l <= node.m) && (node.m <= cmd_data_i);
`else
    order_ok = 1'b1;
`endif
  end

  qtree_init_sweep #(
    .STAGES  (STAGES),
    .A_WIDTH (A_WIDTH),
    .SG_WIDTH(SG_WIDTH)
  ) u_sweep (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(sweep_start),
    .adv_i  (state == ST_INIT),
    .stage_o(sw_stage),
    .addr_o (sw_addr),
    .done_o (sw_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      node       <= '0;
      node_stage <= '0;
      node_addr  <= '0;
      wr_en_o    <= '0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      done_o     <= 1'b0;
`ifdef QTREE_ORDER_CHECK_EN
      err_o      <= 1'b0;
`endif
    end else begin
      done_o  <= 1'b0;
      wr_en_o <= '0;
      if (sweep_start) begin
        state     <= ST_INIT;
        node      <= '0;
        wr_en_o   <= STAGES'(1) << sw_stage;
        wr_addr_o <= sw_addr;
        wr_data_o <= '1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hs && cmd_first_i) begin
              node.l     <= cmd_data_i;
              node_stage <= cmd_stage_i;
              node_addr  <= cmd_addr_i;
              state      <= ST_GET_M;
            end
          end
          ST_GET_M, ST_GET_R: begin
            if (hs && cmd_first_i) begin
              // Resync: a new first word replaces whatever was collected.
              node.l     <= cmd_data_i;
              node_stage <= cmd_stage_i;
              node_addr  <= cmd_addr_i;
              state      <= ST_GET_M;
            end else if (hs && state == ST_GET_M) begin
              node.m <= cmd_data_i;
              state  <= ST_GET_R;
            end else if (hs) begin
              state <= ST_WRITE;
              if (stage_ok && order_ok) begin
                wr_en_o   <= STAGES'(1) << node_stage;
                wr_addr_o <= node_addr & addr_mask;
                wr_data_o <= wr_word;
              end
`ifdef QTREE_ORDER_CHECK_EN
              if (!order_ok) err_o <= 1'b1;
`endif
            end
          end
          ST_WRITE: state <= ST_IDLE;
          ST_INIT: begin
            if (sw_done) begin
              state  <= ST_IDLE;
              done_o <= 1'b1;
            end else begin
              wr_en_o   <= STAGES'(1) << sw_stage;
              wr_addr_o <= sw_addr;
              wr_data_o <= '1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef QTREE_ORDER_CHECK_EN
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_qtree_ctrl_writer.sv
// tb_qtree_ctrl_writer: directed checks of node assembly, resync, invalid stage,
// order check (either build), init sweep and mid-operation reset.
// SG_WIDTH is widened to 3 so that stage 7 can be driven.
module tb_qtree_ctrl_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_first = 1'b0;
  logic [2:0]  cmd_stage = '0;
  logic [5:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        init = 1'b0;
  logic [3:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [47:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ones_cnt = 0;
  int done_cnt = 0;
  logic [63:0] s3_seen = '0;

  always #5 clk = ~clk;

  qtree_ctrl_writer #(
    .STAGES(4), .D_WIDTH(16), .A_WIDTH(6), .SG_WIDTH(3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_first_i(cmd_first),
    .cmd_stage_i(cmd_stage),
    .cmd_addr_i (cmd_addr),
    .cmd_data_i (cmd_data),
    .init_i     (init),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en != 4'b0000) begin
        wr_cnt++;
        if (wr_data == 48'hFFFF_FFFF_FFFF) begin
          ones_cnt++;
          if (wr_en == 4'b1000) s3_seen[wr_addr] = 1'b1;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic first, input logic [2:0] stg, input logic [5:0] adr,
                      input logic [15:0] dat);
    cmd_valid = 1'b1;
    cmd_first = first;
    cmd_stage = stg;
    cmd_addr  = adr;
    cmd_data  = dat;
    tick();
    cmd_valid = 1'b0;
    cmd_first = 1'b0;
  endtask

  initial begin
    int w0;
    int o0;
    int n;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    // Single node: stage 2, addr 5
    send(1'b1, 3'd2, 6'd5, 16'h0010);
    chk("single_busy_getm", 64'(busy), 64'd1);
    chk("single_no_wr_l", 64'(wr_en), 64'd0);
    send(1'b0, 3'd0, 6'd0, 16'h0020);
    chk("single_ready_getr", 64'(cmd_ready), 64'd1);
    send(1'b0, 3'd0, 6'd0, 16'h0030);
    chk("single_wr_en", 64'(wr_en), 64'b0100);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'h0010_0020_0030);
    chk("single_ready_low", 64'(cmd_ready), 64'd0);
    tick();
    chk("single_ready_back", 64'(cmd_ready), 64'd1);
    chk("single_en_clear", 64'(wr_en), 64'd0);
    chk("single_busy_clear", 64'(busy), 64'd0);
    chk("single_addr_hold", 64'(wr_addr), 64'd5);

    // Address masking: stage 1 keeps only 2 address bits
    send(1'b1, 3'd1, 6'h3D, 16'h0011);
    send(1'b0, 3'd0, 6'd0, 16'h0022);
    send(1'b0, 3'd0, 6'd0, 16'h0033);
    chk("mask_wr_en", 64'(wr_en), 64'b0010);
    chk("mask_wr_addr", 64'(wr_addr), 64'd1);
    tick();

    // Resync: partial {1,2} abandoned by a new first word
    w0 = wr_cnt;
    send(1'b1, 3'd3, 6'd10, 16'h0001);
    send(1'b0, 3'd0, 6'd0, 16'h0002);
    send(1'b1, 3'd1, 6'd3, 16'h0007);
    chk("resync_no_wr", 64'(wr_en), 64'd0);
    chk("resync_ready", 64'(cmd_ready), 64'd1);
    send(1'b0, 3'd0, 6'd0, 16'h0008);
    send(1'b0, 3'd0, 6'd0, 16'h0009);
    chk("resync_wr_en", 64'(wr_en), 64'b0010);
    chk("resync_wr_addr", 64'(wr_addr), 64'd3);
    chk("resync_wr_data", 64'(wr_data), 64'h0007_0008_0009);
    tick();
    chk("resync_one_write", 64'(wr_cnt - w0), 64'd1);

    // Invalid stage 7: write dropped, still one WRITE cycle
    w0 = wr_cnt;
    send(1'b1, 3'd7, 6'd1, 16'h000A);
    send(1'b0, 3'd0, 6'd0, 16'h000B);
    send(1'b0, 3'd0, 6'd0, 16'h000C);
    chk("bad_stage_no_en", 64'(wr_en), 64'd0);
    chk("bad_stage_write_cycle", 64'(cmd_ready), 64'd0);
    chk("bad_stage_busy", 64'(busy), 64'd1);
    tick();
    chk("bad_stage_idle", 64'(busy), 64'd0);
    chk("bad_stage_addr_hold", 64'(wr_addr), 64'd3);
    chk("bad_stage_data_hold", 64'(wr_data), 64'h0007_0008_0009);
    chk("bad_stage_no_write", 64'(wr_cnt - w0), 64'd0);

    // Order check on node {5,3,9}
    send(1'b1, 3'd2, 6'd1, 16'h0005);
    send(1'b0, 3'd0, 6'd0, 16'h0003);
    send(1'b0, 3'd0, 6'd0, 16'h0009);
`ifdef QTREE_ORDER_CHECK_EN
    chk("order_suppressed", 64'(wr_en), 64'd0);
    tick();
    chk("order_err_set", 64'(err), 64'd1);
    send(1'b1, 3'd2, 6'd2, 16'h0001);
    send(1'b0, 3'd0, 6'd0, 16'h0002);
    send(1'b0, 3'd0, 6'd0, 16'h0003);
    chk("order_good_en", 64'(wr_en), 64'b0100);
    chk("order_good_data", 64'(wr_data), 64'h0001_0002_0003);
    tick();
    chk("order_err_sticky", 64'(err), 64'd1);
`else
    chk("order_written_en", 64'(wr_en), 64'b0100);
    chk("order_written_data", 64'(wr_data), 64'h0005_0003_0009);
    tick();
    chk("order_err_zero", 64'(err), 64'd0);
`endif

    // Node write, then init_i during its WRITE cycle
    send(1'b1, 3'd3, 6'd63, 16'h0100);
    send(1'b0, 3'd0, 6'd0, 16'h0200);
    send(1'b0, 3'd0, 6'd0, 16'h0300);
    chk("pre_init_wr_en", 64'(wr_en), 64'b1000);
    chk("pre_init_wr_addr", 64'(wr_addr), 64'd63);
    s3_seen = '0;
    init = 1'b1;
    tick();
    init = 1'b0;
    w0 = wr_cnt;
    o0 = ones_cnt;
    chk("init_first_en", 64'(wr_en), 64'b0001);
    chk("init_first_addr", 64'(wr_addr), 64'd0);
    chk("init_first_data", 64'(wr_data), 64'hFFFF_FFFF_FFFF);
    chk("init_ready_low", 64'(cmd_ready), 64'd0);
    chk("init_busy", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 200) begin
      if (n == 40) init = 1'b1;
      tick();
      init = 1'b0;
      n++;
    end
    chk("init_cycles", 64'(n), 64'd86);
    chk("init_done", 64'(done), 64'd1);
    chk("init_write_count", 64'(wr_cnt - w0), 64'd85);
    chk("init_ones_count", 64'(ones_cnt - o0), 64'd85);
    chk("init_stage3_cover", s3_seen, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("init_idle_ready", 64'(cmd_ready), 64'd1);
    chk("init_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("init_done_pulse", 64'(done), 64'd0);
    chk("init_done_once", 64'(done_cnt), 64'd1);

    // Reset while in GET_R
    w0 = wr_cnt;
    send(1'b1, 3'd1, 6'd2, 16'h0010);
    send(1'b0, 3'd0, 6'd0, 16'h0020);
    chk("rst_mid_getr", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    chk("rst_mid_no_en", 64'(wr_en), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    send(1'b0, 3'd0, 6'd0, 16'h0030);
    chk("rst_r_discard_busy", 64'(busy), 64'd0);
    chk("rst_r_discard_en", 64'(wr_en), 64'd0);
    tick();
    chk("rst_r_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
